audio_pwm_synth: RTL and testbench

Multi-channel square-wave tone synthesiser with a built-in PWM DAC, for the demoscene top level alongside the VGA generator. It is the parametrised successor to the single fixed-sample audio path. Each of NUM_CH channels has its own divider, volume and enable, programmed through a one-cycle write port. Channel levels are summed with saturation, latched once per PWM frame, and emitted as a 1-bit PWM stream.

---
 rtl/audio_pwm_synth.sv | 155 +++++++++++++++
 tb/tb_audio_pwm_synth.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/audio_pwm_synth.sv
// Multi-channel square-wave tone synthesiser with a saturating mixer and PWM DAC.
// Optional LFSR noise channel at index NUM_CH when AUDIO_SYNTH_NOISE_EN is defined.
module audio_pwm_synth #(
  parameter int unsigned NUM_CH = 2,
  parameter int unsigned DIV_W  = 16,
  parameter int unsigned VOL_W  = 4,
  parameter int unsigned PWM_W  = 8,
  localparam int unsigned CH_W  = ($clog2(NUM_CH + 1) > 1) ? $clog2(NUM_CH + 1) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_we,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [DIV_W-1:0]  cfg_div,
  input  logic [VOL_W-1:0]  cfg_vol,
  input  logic              cfg_en,
  output logic [NUM_CH-1:0] ch_out,
  output logic [PWM_W-1:0]  sample,
  output logic              sample_tick,
  output logic              pwm_out
);

  localparam int unsigned SHIFT = PWM_W - VOL_W;
  localparam int unsigned SUM_W = PWM_W + $clog2(NUM_CH + 2);
  localparam logic [PWM_W-1:0] PWM_MAX = '1;

  logic [PWM_W-1:0] levels [NUM_CH];

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] cnt_q;
    logic [VOL_W-1:0] vol_q;
    logic             en_q;
    logic             sq_q;
    logic             wr;
    logic             active;

    assign wr     = cfg_we && (cfg_ch == CH_W'(i));
    assign active = en_q && (div_q != '0);

    // A write restarts the channel phase and takes priority over a toggle.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        div_q <= '0;
        cnt_q <= '0;
        vol_q <= '0;
        en_q  <= 1'b0;
        sq_q  <= 1'b0;
      end else if (wr) begin
        div_q <= cfg_div;
        vol_q <= cfg_vol;
        en_q  <= cfg_en;
        cnt_q <= '0;
        sq_q  <= 1'b0;
      end else if (active) begin
        if (cnt_q == div_q - DIV_W'(1)) begin
          cnt_q <= '0;
          sq_q  <= ~sq_q;
        end else begin
          cnt_q <= cnt_q + DIV_W'(1);
        end
      end else begin
        cnt_q <= '0;
        sq_q  <= 1'b0;
      end
    end

    assign ch_out[i] = sq_q;
    assign levels[i] = sq_q ? (PWM_W'(vol_q) << SHIFT) : '0;
  end

`ifdef AUDIO_SYNTH_NOISE_EN
  logic [DIV_W-1:0] nz_div_q;
  logic [DIV_W-1:0] nz_cnt_q;
  logic [VOL_W-1:0] nz_vol_q;
  logic             nz_en_q;
  logic [15:0]      lfsr_q;
  logic             nz_wr;
  logic             nz_active;
  logic             lfsr_fb;
  logic [PWM_W-1:0] nz_level;

  assign nz_wr     = cfg_we && (cfg_ch == CH_W'(NUM_CH));
  assign nz_active = nz_en_q && (nz_div_q != '0);
  // Taps 16,14,13,11 expressed as a right-shifting Fibonacci register.
  assign lfsr_fb   = lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      nz_div_q <= '0;
      nz_cnt_q <= '0;
      nz_vol_q <= '0;
      nz_en_q  <= 1'b0;
      lfsr_q   <= 16'hACE1;
    end else if (nz_wr) begin
      nz_div_q <= cfg_div;
      nz_vol_q <= cfg_vol;
      nz_en_q  <= cfg_en;
      nz_cnt_q <= '0;
      lfsr_q   <= 16'hACE1;
    end else if (nz_active) begin
      if (nz_cnt_q == nz_div_q - DIV_W'(1)) begin
        nz_cnt_q <= '0;
        lfsr_q   <= {lfsr_fb, lfsr_q[15:1]};
      end else begin
        nz_cnt_q <= nz_cnt_q + DIV_W'(1);
      end
    end else begin
      nz_cnt_q <= '0;
    end
  end

  assign nz_level = (nz_active && lfsr_q[0]) ? (PWM_W'(nz_vol_q) << SHIFT) : '0;
`endif

  logic [SUM_W-1:0] sum;
  logic [PWM_W-1:0] mix;

  always_comb begin
    sum = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      sum = sum + SUM_W'(levels[i]);
    end
`ifdef AUDIO_SYNTH_NOISE_EN
    sum = sum + SUM_W'(nz_level);
`endif
    mix = (sum > SUM_W'(PWM_MAX)) ? PWM_MAX : sum[PWM_W-1:0];
  end

  logic [PWM_W-1:0] pc_q;
  logic [PWM_W-1:0] sample_q;
  logic             tick_q;
  logic             pwm_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q     <= '0;
      sample_q <= '0;
      tick_q   <= 1'b0;
      pwm_q    <= 1'b0;
    end else begin
      pc_q   <= pc_q + PWM_W'(1);
      tick_q <= (pc_q == PWM_MAX);
      if (pc_q == PWM_MAX) begin
        sample_q <= mix;
      end
      pwm_q <= (pc_q < sample_q);
    end
  end

  assign sample      = sample_q;
  assign sample_tick = tick_q;
  assign pwm_out     = pwm_q;

endmodule

// File: tb/tb_audio_pwm_synth.sv
// Directed self-checking bench for audio_pwm_synth (default parameters, noise channel disabled).
module tb_audio_pwm_synth;

  logic        clk;
  logic        rst_n;
  logic        cfg_we;
  logic [1:0]  cfg_ch;
  logic [15:0] cfg_div;
  logic [3:0]  cfg_vol;
  logic        cfg_en;
  logic [1:0]  ch_out;
  logic [7:0]  sample;
  logic        sample_tick;
  logic        pwm_out;

  int n_checks = 0;
  int n_errors = 0;

  audio_pwm_synth dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cfg_we      (cfg_we),
    .cfg_ch      (cfg_ch),
    .cfg_div     (cfg_div),
    .cfg_vol     (cfg_vol),
    .cfg_en      (cfg_en),
    .ch_out      (ch_out),
    .sample      (sample),
    .sample_tick (sample_tick),
    .pwm_out     (pwm_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Called at posedge+1; the write lands on the next edge.
  task automatic cfg_write(input logic [1:0] ch, input logic [15:0] div, input logic [3:0] vol,
                           input logic en);
    cfg_we  = 1'b1;
    cfg_ch  = ch;
    cfg_div = div;
    cfg_vol = vol;
    cfg_en  = en;
    @(posedge clk);
    #1;
    cfg_we  = 1'b0;
  endtask

  // Finds a tick whose latched mix came from channel pattern pat in the preceding cycle.
  task automatic wait_tick(input logic [1:0] pat, input int budget, output logic found);
    logic [1:0] prev;
    prev  = ch_out;
    found = 1'b0;
    for (int i = 0; i < budget && !found; i++) begin
      @(posedge clk);
      #1;
      if (sample_tick && prev == pat) found = 1'b1;
      else prev = ch_out;
    end
  endtask

  task automatic check_frame(input string tag, input logic [1:0] pat, input int exp_sample,
                             input int exp_high);
    logic found;
    int   highs;
    wait_tick(pat, 4000, found);
    check({tag, "_tick_found"}, 32'(found), 1);
    if (found) begin
      check({tag, "_sample"}, 32'(sample), exp_sample);
      highs = 0;
      repeat (256) begin
        @(posedge clk);
        #1;
        if (pwm_out) highs++;
      end
      check({tag, "_pwm_high"}, highs, exp_high);
    end
  endtask

  task automatic check_silent(input string tag);
    int   bad;
    logic found;
    bad = 0;
    repeat (300) begin
      @(posedge clk);
      #1;
      if (ch_out !== 2'b00) bad++;
    end
    check({tag, "_ch_out"}, bad, 0);
    wait_tick(2'b00, 600, found);
    check({tag, "_tick_found"}, 32'(found), 1);
    check({tag, "_sample"}, 32'(sample), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int bad, bad_tick, ticks, highs, first_tick;

    rst_n   = 1'b0;
    cfg_we  = 1'b0;
    cfg_ch  = '0;
    cfg_div = '0;
    cfg_vol = '0;
    cfg_en  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ch_out", 32'(ch_out), 0);
    check("rst_sample", 32'(sample), 0);
    check("rst_tick", 32'(sample_tick), 0);
    check("rst_pwm", 32'(pwm_out), 0);
    rst_n = 1'b1;

    // Idle run: ticks every 256 edges, everything else silent.
    bad = 0; bad_tick = 0; ticks = 0; highs = 0;
    for (int k = 1; k <= 1024; k++) begin
      @(posedge clk);
      #1;
      if (sample_tick) begin
        ticks++;
        if (k % 256 != 0) bad_tick++;
      end
      if (pwm_out) highs++;
      if (ch_out !== 2'b00 || sample !== 8'd0) bad++;
    end
    check("idle_tick_count", ticks, 4);
    check("idle_tick_place", bad_tick, 0);
    check("idle_pwm_high", highs, 0);
    check("idle_outputs", bad, 0);

    // div=4: first rise 4 edges after the write, then period 8.
    cfg_write(2'd0, 16'd4, 4'd15, 1'b1);
    bad = 0;
    for (int k = 1; k <= 16; k++) begin
      @(posedge clk);
      #1;
      if (k == 3) check("tone_before_rise", 32'(ch_out[0]), 0);
      if (k == 4) check("tone_first_rise", 32'(ch_out[0]), 1);
      if (k == 8) check("tone_first_fall", 32'(ch_out[0]), 0);
      if (ch_out !== {1'b0, 1'(((k / 4) % 2))}) bad++;
    end
    check("tone_period", bad, 0);

    // Single channel at half volume.
    cfg_write(2'd0, 16'd1000, 4'd8, 1'b1);
    check_frame("half_vol", 2'b01, 128, 128);

    // Two full-volume channels overlap: 480 saturates to 255.
    cfg_write(2'd0, 16'd1000, 4'd15, 1'b1);
    cfg_write(2'd1, 16'd1000, 4'd15, 1'b1);
    check_frame("saturate", 2'b11, 255, 255);

    // Disabled and zero-divider channels stay silent.
    cfg_write(2'd1, 16'd1000, 4'd15, 1'b0);
    cfg_write(2'd0, 16'd4, 4'd15, 1'b0);
    check_silent("en_off");
    cfg_write(2'd0, 16'd0, 4'd15, 1'b1);
    check_silent("div_zero");

`ifndef AUDIO_SYNTH_NOISE_EN
    cfg_write(2'd2, 16'd4, 4'd15, 1'b1);
    check_silent("idx2_ignored");
    cfg_write(2'd3, 16'd4, 4'd15, 1'b1);
    check_silent("idx3_ignored");
`endif

    // Mid-frame reset while pwm_out is high.
    cfg_write(2'd0, 16'd1000, 4'd8, 1'b1);
    begin
      logic found;
      wait_tick(2'b01, 4000, found);
      check("pre_reset_tick_found", 32'(found), 1);
    end
    repeat (10) @(posedge clk);
    #1;
    check("pre_reset_pwm", 32'(pwm_out), 1);
    rst_n = 1'b0;
    #1;
    check("async_rst_ch_out", 32'(ch_out), 0);
    check("async_rst_sample", 32'(sample), 0);
    check("async_rst_tick", 32'(sample_tick), 0);
    check("async_rst_pwm", 32'(pwm_out), 0);
    #2;
    rst_n = 1'b1;

    bad = 0; ticks = 0; highs = 0; first_tick = 0;
    for (int k = 1; k <= 1100; k++) begin
      @(posedge clk);
      #1;
      if (sample_tick) begin
        ticks++;
        if (first_tick == 0) first_tick = k;
      end
      if (pwm_out) highs++;
      if (ch_out !== 2'b00 || sample !== 8'd0) bad++;
    end
    check("post_rst_first_tick", first_tick, 256);
    check("post_rst_tick_count", ticks, 4);
    check("post_rst_pwm_high", highs, 0);
    check("post_rst_no_tone", bad, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
